// File: rtl/ps2_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_pkg                                                                  |
// | PS/2 prefix and control bytes, decoder state encoding, event layout.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package ps2_pkg;

    localparam int CODE_W = 8;
    localparam int EVT_W  = CODE_W + 2;
    localparam int CNT_W  = 5;

    localparam logic [7:0] C_PFX_EXT   = 8'hE0;
    localparam logic [7:0] C_PFX_BRK   = 8'hF0;
    localparam logic [7:0] C_PFX_PAUSE = 8'hE1;

    localparam logic [7:0] C_CTL_BAT    = 8'hAA;
    localparam logic [7:0] C_CTL_ACK    = 8'hFA;
    localparam logic [7:0] C_CTL_RESEND = 8'hFE;
    localparam logic [7:0] C_CTL_ECHO   = 8'hEE;
    localparam logic [7:0] C_CTL_ERR0   = 8'h00;
    localparam logic [7:0] C_CTL_ERR1   = 8'hFF;

    // Bytes that follow the 0xE1 pause prefix before the sequence is complete.
    localparam logic [2:0] C_PAUSE_SKIP_LEN = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_GOT_E0     = 3'd1,
        ST_GOT_F0     = 3'd2,
        ST_GOT_E0F0   = 3'd3,
        ST_PAUSE_SKIP = 3'd4
    } dec_state_t;

    typedef struct packed {
        logic              ext;
        logic              brk;
        logic [CODE_W-1:0] code;
    } evt_t;

    function automatic logic is_ctrl_byte(input logic [7:0] b);
        return (b == C_CTL_BAT)  || (b == C_CTL_ACK)  || (b == C_CTL_RESEND) ||
               (b == C_CTL_ECHO) || (b == C_CTL_ERR0) || (b == C_CTL_ERR1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_scancode_decoder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_scancode_decoder_if                                                  |
// | Byte input strobe and key-event queue access of the scancode decoder.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface ps2_scancode_decoder_if;
    import ps2_pkg::*;

    logic [7:0]       byte_in;
    logic             byte_valid;
    logic             evt_pop;
    logic             evt_clr_ovf;
    logic [EVT_W-1:0] evt_data;
    logic             evt_empty;
    logic [CNT_W-1:0] evt_count;
    logic             evt_ovf;

    modport master (
        output byte_in, byte_valid, evt_pop, evt_clr_ovf,
        input  evt_data, evt_empty, evt_count, evt_ovf
    );

    modport slave (
        input  byte_in, byte_valid, evt_pop, evt_clr_ovf,
        output evt_data, evt_empty, evt_count, evt_ovf
    );
endinterface
`default_nettype wire

// File: rtl/ps2_evt_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_evt_fifo                                                             |
// | Power-of-two FIFO with zero-latency head, count and sticky overflow.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ps2_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10,
    parameter int CNT_W = 5
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    input  wire logic             pop,
    input  wire logic             clr_ovf,
    output logic      [WIDTH-1:0] head_data,
    output logic                  empty,
    output logic                  full,
    output logic      [CNT_W-1:0] count,
    output logic                  ovf
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_ovf;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == C_DEPTH);
    assign w_do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign w_do_push = push && (!full || w_do_pop);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_nxt;
            if (push && !w_do_push)
                r_ovf <= 1'b1;
            else if (clr_ovf)
                r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

    assign head_data = empty ? '0 : r_mem[r_rd_ptr];
    assign count     = r_count;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: rtl/ps2_scancode_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_scancode_decoder                                                     |
// | PS/2 set-2 prefix decoder feeding a key-event queue. Optional typematic  |
// | repeat filter enabled by defining PS2_DEC_TYPEMATIC_FILTER_EN.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input wire logic              CLOCK_50,
    input wire logic              Resetn,
    ps2_scancode_decoder_if.slave bus
);
    dec_state_t r_state;
    dec_state_t w_state_nxt;
    logic [2:0] r_skip;
    logic       w_dec_push;
    evt_t       w_dec_evt;
    logic       w_fifo_push;
    logic       w_fifo_full_unused;

    logic w_is_e0;
    logic w_is_f0;
    logic w_is_e1;
    assign w_is_e0 = (bus.byte_in == C_PFX_EXT);
    assign w_is_f0 = (bus.byte_in == C_PFX_BRK);
    assign w_is_e1 = (bus.byte_in == C_PFX_PAUSE);

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn)
            r_skip <= 3'd0;
        else if (bus.byte_valid) begin
            if (r_state == ST_IDLE && w_is_e1)
                r_skip <= C_PAUSE_SKIP_LEN;
            else if (r_state == ST_PAUSE_SKIP)
                r_skip <= r_skip - 3'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.byte_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_is_e0)      w_state_nxt = ST_GOT_E0;
                    else if (w_is_f0) w_state_nxt = ST_GOT_F0;
                    else if (w_is_e1) w_state_nxt = ST_PAUSE_SKIP;
                end
                ST_GOT_E0: begin
                    if (w_is_f0)       w_state_nxt = ST_GOT_E0F0;
                    else if (!w_is_e0) w_state_nxt = ST_IDLE;
                end
                ST_GOT_F0: begin
                    if (!w_is_f0) w_state_nxt = ST_IDLE;
                end
                ST_GOT_E0F0: begin
                    if (!(w_is_f0 || w_is_e0)) w_state_nxt = ST_IDLE;
                end
                ST_PAUSE_SKIP: begin
                    if (r_skip == 3'd1) w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_dec_push = 1'b0;
        w_dec_evt  = '{ext: 1'b0, brk: 1'b0, code: bus.byte_in};
        if (bus.byte_valid) begin
            case (r_state)
                ST_IDLE: begin
                    w_dec_push = !(w_is_e0 || w_is_f0 || w_is_e1 || is_ctrl_byte(bus.byte_in));
                end
                ST_GOT_E0: begin
                    w_dec_push = !(w_is_f0 || w_is_e0);
                    w_dec_evt  = '{ext: 1'b1, brk: 1'b0, code: bus.byte_in};
                end
                ST_GOT_F0: begin
                    w_dec_push = !w_is_f0;
                    w_dec_evt  = '{ext: 1'b0, brk: 1'b1, code: bus.byte_in};
                end
                ST_GOT_E0F0: begin
                    w_dec_push = !(w_is_f0 || w_is_e0);
                    w_dec_evt  = '{ext: 1'b1, brk: 1'b1, code: bus.byte_in};
                end
                ST_PAUSE_SKIP: begin
                    w_dec_push = (r_skip == 3'd1);
                    w_dec_evt  = '{ext: 1'b0, brk: 1'b0, code: C_PFX_PAUSE};
                end
                default: w_dec_push = 1'b0;
            endcase
        end
    end

`ifdef PS2_DEC_TYPEMATIC_FILTER_EN
    logic       r_held_valid;
    logic       r_held_ext;
    logic [7:0] r_held_code;
    logic       w_held_match;
    logic       w_is_pause;

    // Pause has no break code, so it never takes part in repeat filtering.
    assign w_is_pause   = (r_state == ST_PAUSE_SKIP);
    assign w_held_match = r_held_valid && (r_held_ext == w_dec_evt.ext) &&
                          (r_held_code == w_dec_evt.code);
    assign w_fifo_push  = w_dec_push && !(w_held_match && !w_dec_evt.brk && !w_is_pause);

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_held_valid <= 1'b0;
            r_held_ext   <= 1'b0;
            r_held_code  <= 8'h00;
        end else if (w_dec_push && !w_is_pause) begin
            if (!w_dec_evt.brk) begin
                r_held_valid <= 1'b1;
                r_held_ext   <= w_dec_evt.ext;
                r_held_code  <= w_dec_evt.code;
            end else if (w_held_match) begin
                r_held_valid <= 1'b0;
            end
        end
    end
`else
    assign w_fifo_push = w_dec_push;
`endif

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (CLOCK_50),
        .rst_n     (Resetn),
        .push      (w_fifo_push),
        .push_data (w_dec_evt),
        .pop       (bus.evt_pop),
        .clr_ovf   (bus.evt_clr_ovf),
        .head_data (bus.evt_data),
        .empty     (bus.evt_empty),
        .full      (w_fifo_full_unused),
        .count     (bus.evt_count),
        .ovf       (bus.evt_ovf)
    );

endmodule
`default_nettype wire

// File: tb/tb_ps2_scancode_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ps2_scancode_decoder                                                  |
// | Vector table, directed corner sequences and random traffic vs. a model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ps2_scancode_decoder;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ps2_scancode_decoder_if bus();

    ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .CLOCK_50 (clk),
        .Resetn   (rst_n),
        .bus      (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pending prefix flags, pause byte countdown, event queue.
    int         m_pause;
    bit         m_ext, m_brk;
    bit         m_hv, m_hext;
    logic [7:0] m_hcode;
    logic [9:0] mq[$];
    bit         m_ovf;

    typedef struct {
        bit         v;
        logic [7:0] b;
        bit         pop;
        bit         e_empty;
        int         e_count;
        logic [9:0] e_data;
    } vec_t;
    vec_t tbl[$];

    function automatic void model_reset();
        m_pause = 0; m_ext = 0; m_brk = 0;
        m_hv = 0; m_hext = 0; m_hcode = 8'h00;
        mq.delete(); m_ovf = 0;
    endfunction

    function automatic void model_decode(input logic [7:0] b, output bit push, output logic [9:0] ev);
        bit idle;
        idle = !m_ext && !m_brk;
        push = 0;
        ev   = '0;
        if (m_pause > 0) begin
            m_pause--;
            if (m_pause == 0) begin push = 1; ev = {2'b00, 8'hE1}; end
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE0 && (!m_brk || m_ext)) begin
            m_ext = 1;
        end else if (idle && b == 8'hE1) begin
            m_pause = 7;
        end else if (idle && (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) begin
            push = 0;
        end else begin
            ev = {m_ext, m_brk, b};
            push = 1;
            m_ext = 0; m_brk = 0;
`ifdef PS2_DEC_TYPEMATIC_FILTER_EN
            if (!ev[8]) begin
                if (m_hv && m_hext == ev[9] && m_hcode == b) push = 0;
                m_hv = 1; m_hext = ev[9]; m_hcode = b;
            end else if (m_hv && m_hext == ev[9] && m_hcode == b) begin
                m_hv = 0;
            end
`endif
        end
    endfunction

    function automatic void model_queue(input bit push, input logic [9:0] ev, input bit pop, input bit clr);
        bit full, dpop;
        full = (mq.size() == DEPTH);
        dpop = pop && (mq.size() > 0);
        if (dpop) void'(mq.pop_front());
        if (push && (!full || dpop)) mq.push_back(ev);
        if (push && full && !dpop) m_ovf = 1;
        else if (clr) m_ovf = 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit v, input logic [7:0] b, input bit pop, input bit clr);
        bit         push;
        logic [9:0] ev;
        bus.byte_valid = v; bus.byte_in = b; bus.evt_pop = pop; bus.evt_clr_ovf = clr;
        @(posedge clk);
        push = 0; ev = '0;
        if (v) model_decode(b, push, ev);
        model_queue(push, ev, pop, clr);
        #1;
        bus.byte_valid = 0; bus.evt_pop = 0; bus.evt_clr_ovf = 0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".empty"}, bus.evt_empty, (mq.size() == 0));
        check({tag, ".count"}, bus.evt_count, mq.size());
        check({tag, ".ovf"},   bus.evt_ovf,   m_ovf);
        if (mq.size() > 0) check({tag, ".data"}, bus.evt_data, mq[0]);
    endtask

    task automatic do_reset();
        bus.byte_valid = 0; bus.byte_in = 8'h00; bus.evt_pop = 0; bus.evt_clr_ovf = 0;
        rst_n = 1'b0;
        #3;
        check("rst.empty", bus.evt_empty, 1);
        check("rst.count", bus.evt_count, 0);
        check("rst.ovf",   bus.evt_ovf,   0);
        check("rst.data",  bus.evt_data,  0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic add(input bit v, input logic [7:0] b, input bit pop,
                       input bit e_empty, input int e_count, input logic [9:0] e_data);
        tbl.push_back('{v: v, b: b, pop: pop, e_empty: e_empty, e_count: e_count, e_data: e_data});
    endtask

    task automatic push_bytes(input logic [7:0] b0, input logic [7:0] b1, input int n);
        cycle(1, b0, 0, 0);
        if (n > 1) cycle(1, b1, 0, 0);
    endtask

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 11))
            0:       return 8'hE0;
            1:       return 8'hF0;
            2:       return 8'hE1;
            3:       return 8'hAA;
            4:       return 8'hFA;
            5:       return 8'h00;
            6, 7:    return 8'h1C;
            8:       return 8'h75;
            9:       return 8'h14;
            10:      return 8'hFF;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset();

        // Table: basic make/break, extended, control drop, pause, prefix corners.
        add(0, 8'h1C, 0, 1, 0, 10'h000);
        add(1, 8'h1C, 0, 0, 1, 10'h01C);
        add(0, 8'h00, 1, 1, 0, 10'h000);
        add(1, 8'hF0, 0, 1, 0, 10'h000);
        add(1, 8'h1C, 0, 0, 1, 10'h11C);
        add(0, 8'h00, 1, 1, 0, 10'h000);
        add(1, 8'hE0, 0, 1, 0, 10'h000);
        add(1, 8'h75, 0, 0, 1, 10'h275);
        add(1, 8'hE0, 0, 0, 1, 10'h275);
        add(1, 8'hF0, 0, 0, 1, 10'h275);
        add(1, 8'h75, 0, 0, 2, 10'h275);
        add(0, 8'h00, 1, 0, 1, 10'h375);
        add(0, 8'h00, 1, 1, 0, 10'h000);
        add(1, 8'hAA, 0, 1, 0, 10'h000);
        add(1, 8'hFA, 0, 1, 0, 10'h000);
        add(1, 8'h1C, 0, 0, 1, 10'h01C);
        add(0, 8'h00, 1, 1, 0, 10'h000);
        add(1, 8'hE1, 0, 1, 0, 10'h000);
        add(1, 8'h14, 0, 1, 0, 10'h000);
        add(1, 8'h77, 0, 1, 0, 10'h000);
        add(1, 8'hE1, 0, 1, 0, 10'h000);
        add(1, 8'hF0, 0, 1, 0, 10'h000);
        add(1, 8'h14, 0, 1, 0, 10'h000);
        add(1, 8'hF0, 0, 1, 0, 10'h000);
        add(1, 8'h77, 0, 0, 1, 10'h0E1);
        add(1, 8'h2A, 0, 0, 2, 10'h0E1);
        add(0, 8'h00, 1, 0, 1, 10'h02A);
        add(0, 8'h00, 1, 1, 0, 10'h000);
        add(1, 8'hF0, 0, 1, 0, 10'h000);
        add(1, 8'hE0, 0, 0, 1, 10'h1E0);
        add(0, 8'h00, 1, 1, 0, 10'h000);
        add(1, 8'hE0, 0, 1, 0, 10'h000);
        add(1, 8'hE0, 0, 1, 0, 10'h000);
        add(1, 8'h1C, 0, 0, 1, 10'h21C);
        add(0, 8'h00, 1, 1, 0, 10'h000);

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].v, tbl[i].b, tbl[i].pop, 0);
            check($sformatf("vec%0d.empty", i), bus.evt_empty, tbl[i].e_empty);
            check($sformatf("vec%0d.count", i), bus.evt_count, tbl[i].e_count);
            if (!tbl[i].e_empty)
                check($sformatf("vec%0d.data", i), bus.evt_data, tbl[i].e_data);
        end

        // Overflow on a full queue, FIFO order, sticky flag and its clear.
        do_reset();
        cycle(1, 8'h15, 0, 0); cycle(1, 8'h1D, 0, 0); cycle(1, 8'h24, 0, 0);
        cycle(1, 8'h2D, 0, 0); cycle(1, 8'h2C, 0, 0);
        check("ovf.count", bus.evt_count, 4);
        check("ovf.flag",  bus.evt_ovf,   1);
        check("ovf.head0", bus.evt_data,  10'h015);
        cycle(0, 8'h00, 1, 0); check("ovf.head1", bus.evt_data, 10'h01D);
        cycle(0, 8'h00, 1, 0); check("ovf.head2", bus.evt_data, 10'h024);
        cycle(0, 8'h00, 1, 0); check("ovf.head3", bus.evt_data, 10'h02D);
        cycle(0, 8'h00, 1, 0); check("ovf.drained", bus.evt_empty, 1);
        cycle(0, 8'h00, 0, 1); check("ovf.clr", bus.evt_ovf, 0);
        cycle(0, 8'h00, 1, 0); check("pop_empty.count", bus.evt_count, 0);

        // Push with pop on empty, then push with pop on full, then set beats clear.
        cycle(1, 8'h33, 1, 0);
        check("pp_empty.count", bus.evt_count, 1);
        check("pp_empty.data",  bus.evt_data,  10'h033);
        cycle(1, 8'h3B, 0, 0); cycle(1, 8'h42, 0, 0); cycle(1, 8'h4B, 0, 0);
        cycle(1, 8'h4C, 1, 0);
        check("pp_full.count", bus.evt_count, 4);
        check("pp_full.ovf",   bus.evt_ovf,   0);
        check("pp_full.head",  bus.evt_data,  10'h03B);
        cycle(1, 8'h52, 0, 1);
        check("set_clr.ovf",   bus.evt_ovf,   1);
        check("set_clr.count", bus.evt_count, 4);
        cycle(0, 8'h00, 0, 1);
        check("clr2.ovf", bus.evt_ovf, 0);

        // Reset in the middle of a break prefix and of a pause sequence.
        do_reset();
        cycle(1, 8'hF0, 0, 0);
        do_reset();
        cycle(1, 8'h1C, 0, 0);
        check("rst_brk.count", bus.evt_count, 1);
        check("rst_brk.data",  bus.evt_data,  10'h01C);
        do_reset();
        push_bytes(8'hE1, 8'h14, 2);
        do_reset();
        cycle(1, 8'h1C, 0, 0);
        check("rst_pause.count", bus.evt_count, 1);
        check("rst_pause.data",  bus.evt_data,  10'h01C);

        // Typematic repeats of one key followed by its release.
        do_reset();
        cycle(1, 8'h1C, 0, 0); cycle(1, 8'h1C, 0, 0); cycle(1, 8'h1C, 0, 0);
        cycle(1, 8'hF0, 0, 0); cycle(1, 8'h1C, 0, 0);
`ifdef PS2_DEC_TYPEMATIC_FILTER_EN
        check("typ.count", bus.evt_count, 2);
        check("typ.head0", bus.evt_data, 10'h01C);
        cycle(0, 8'h00, 1, 0); check("typ.head1", bus.evt_data, 10'h11C);
`else
        check("typ.count", bus.evt_count, 4);
        check("typ.head0", bus.evt_data, 10'h01C);
        cycle(0, 8'h00, 1, 0); check("typ.head1", bus.evt_data, 10'h01C);
        cycle(0, 8'h00, 1, 0); check("typ.head2", bus.evt_data, 10'h01C);
        cycle(0, 8'h00, 1, 0); check("typ.head3", bus.evt_data, 10'h11C);
`endif
        check("typ.ovf", bus.evt_ovf, 0);

        // Random traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 9) < 6), rand_byte(),
                  ($urandom_range(0, 19) < 7), ($urandom_range(0, 31) == 0));
            check_model("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, key-event queue depth (power of two, 2..16).
REQ-002 SHALL have port CLOCK_50  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port Resetn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port byte_in  input  8  received PS/2 byte from the PS/2 receiver.
REQ-005 SHALL have port byte_valid  input  1  one-cycle strobe qualifying byte_in.
REQ-006 SHALL have port evt_pop  input  1  consumer removes head event this cycle.
REQ-007 SHALL have port evt_clr_ovf  input  1  clears the sticky overflow flag.
REQ-008 SHALL have port evt_data  output  10  head event {ext, brk, code[7:0]}, valid when evt_empty=0.
REQ-009 SHALL have port evt_empty  output  1  queue empty.
REQ-010 SHALL have port evt_count  output  5  number of queued events.
REQ-011 SHALL have port evt_ovf  output  1  sticky: an event was dropped on a full queue.

Function
REQ-012 SHALL run a prefix FSM with states IDLE, GOT_E0, GOT_F0, GOT_E0F0, PAUSE_SKIP, advancing only on byte_valid.
REQ-013 IDLE: 0xE0 -> GOT_E0; 0xF0 -> GOT_F0; 0xE1 -> PAUSE_SKIP; 0xAA, 0xFA, 0xFE, 0xEE, 0x00, 0xFF dropped, stay IDLE; any other byte -> push {0,0,byte}.
REQ-014 GOT_E0: 0xF0 -> GOT_E0F0; 0xE0 -> stay; other byte -> push {1,0,byte}, IDLE.
REQ-015 GOT_F0: 0xF0 -> stay; other byte -> push {0,1,byte}, IDLE.
REQ-016 GOT_E0F0: 0xF0 or 0xE0 -> stay; other byte -> push {1,1,byte}, IDLE.
REQ-017 PAUSE_SKIP: load 3-bit counter with 7 on entry, decrement per byte_valid regardless of value; on the 7th skipped byte push {0,0,0xE1}, return to IDLE.
REQ-018 Event SHALL be visible at queue head (evt_empty=0) the cycle after the strobe of its final byte; no bytes are lost at back-to-back strobes.
REQ-019 Queue SHALL be FIFO order; evt_data is the head entry, combinationally from storage, no read latency.
REQ-020 evt_pop with evt_empty=1 SHALL be ignored.
REQ-021 Push with queue full and no pop SHALL drop the new event, keep contents unchanged, set evt_ovf.
REQ-022 Simultaneous push and pop when full SHALL succeed both; evt_count unchanged, evt_ovf not set.
REQ-023 Simultaneous push and pop when empty SHALL ignore the pop and store the push (count 1).
REQ-024 evt_ovf set and evt_clr_ovf same cycle SHALL leave evt_ovf=1.
REQ-025 Read/write pointers SHALL wrap modulo FIFO_DEPTH; evt_count ranges 0..FIFO_DEPTH.

Reset
REQ-026 Resetn=0 SHALL asynchronously force FSM to IDLE, skip counter 0, pointers 0, evt_count 0, evt_empty 1, evt_ovf 0, evt_data 0, filter register invalid.
REQ-027 Reset mid-sequence (prefix or pause) SHALL discard the partial sequence; first byte after release is decoded from IDLE.

Configuration
REQ-028 Macro PS2_DEC_TYPEMATIC_FILTER_EN defined: one held-key register {valid, ext, code}; a make equal to the held key is suppressed (not pushed); a non-equal make is pushed and becomes held; a break of the held key is pushed and invalidates it.
REQ-029 Macro undefined: every make, including typematic repeats, is pushed; no held-key register exists.

Structure
REQ-030 Shared package ps2_pkg SHALL hold prefix constants (0xE0, 0xF0, 0xE1), control-byte constants, FSM state enum, event field widths.
REQ-031 Event queue SHALL be sub-module ps2_evt_fifo (parameterized depth/width, full/empty/count/overflow); decoder FSM stays in the top.

Verification
REQ-032 Bytes 0x1C -> pop; 0xF0,0x1C -> events {0,0,0x1C}=0x01C then {0,1,0x1C}=0x11C.
REQ-033 Bytes 0xE0,0x75 then 0xE0,0xF0,0x75 -> events 0x275, 0x375.
REQ-034 Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event 0x0E1, FSM IDLE, count 1.
REQ-035 Bytes 0xAA, 0xFA -> evt_empty stays 1; then 0x1C -> count 1.
REQ-036 Five makes 0x15,0x1D,0x24,0x2D,0x2C, no pops, depth 4 -> count 4, evt_ovf=1, head 0x015, 4th pop 0x02D; evt_clr_ovf -> evt_ovf=0.
REQ-037 Filter on: 0x1C x3, 0xF0,0x1C -> events 0x01C, 0x11C only; filter off -> 0x01C x3, 0x11C; Resetn pulse after 0xF0 then 0x1C -> event 0x01C.
